// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter driven by the shared uart_cr encoding (baud, parity, stop bits).
// Define UART_TX_FIFO_EN to buffer input words in a 16x8 FIFO instead of a single holding register.
`timescale 1ns/1ps
module uart_tx (
    input  logic        clock_125,
    input  logic        rst_n_125,
    input  logic [11:0] uart_cr,
    input  logic [7:0]  pi_data,
    input  logic        pi_flag,
    output logic        tx,
    output logic        tx_ready,
    output logic        tc_flag,
    output logic        ovr_flag
);
    typedef enum logic [2:0] {
        IDLE, START_BIT, SEND, PARITY, STOP_BIT1, STOP_BIT2, FINISH
    } state_t;

    logic [4:0]  rst_sync_q;
    logic        rst_done;
    state_t      state_q, state_d;
    logic [31:0] baud_cnt_max_q, baud_cnt_max_d;
    logic [31:0] cnt_baud_q, cnt_baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_en_q, par_odd_q, two_stop_q;
    logic        tx_q, tx_d;
    logic        ovr_q;
    logic        bit_end, word_avail, pop, push;
    logic [7:0]  word_data;
    logic        unused_cr;

    assign unused_cr = ^{uart_cr[7:6], uart_cr[4], uart_cr[0]};

    // Reset asserts asynchronously, releases five clocks after rst_n_125 rises.
    always_ff @(posedge clock_125 or negedge rst_n_125) begin
        if (!rst_n_125) rst_sync_q <= '0;
        else            rst_sync_q <= {rst_sync_q[3:0], 1'b1};
    end
    assign rst_done = rst_sync_q[4];

    always_comb begin
        baud_cnt_max_d = baud_cnt_max_q;
        if (state_q == IDLE) begin
            case (uart_cr[11:8])
                4'd0:    baud_cnt_max_d = 32'd13020;
                4'd1:    baud_cnt_max_d = 32'd6510;
                4'd2:    baud_cnt_max_d = 32'd3255;
                4'd3:    baud_cnt_max_d = 32'd2170;
                4'd4:    baud_cnt_max_d = 32'd1085;
                4'd5:    baud_cnt_max_d = 32'd125;
                4'd6:    baud_cnt_max_d = 32'd62;
                4'd7:    baud_cnt_max_d = 32'd41;
                4'd8:    baud_cnt_max_d = 32'd31;
                4'd9:    baud_cnt_max_d = 32'd25;
                4'd10:   baud_cnt_max_d = 32'd135;
                4'd11:   baud_cnt_max_d = 32'd542;
                4'd12:   baud_cnt_max_d = 32'd271;
                default: baud_cnt_max_d = baud_cnt_max_q;
            endcase
        end
    end

    assign bit_end = (cnt_baud_q == baud_cnt_max_q - 32'd1);

    always_comb begin
        state_d    = state_q;
        cnt_baud_d = cnt_baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        if (state_q != IDLE && state_q != FINISH)
            cnt_baud_d = bit_end ? 32'd0 : cnt_baud_q + 32'd1;
        case (state_q)
            IDLE: begin
                if (word_avail && uart_cr[1] && baud_cnt_max_q != 32'd0) begin
                    state_d    = START_BIT;
                    pop        = 1'b1;
                    shift_d    = word_data;
                    cnt_baud_d = 32'd0;
                    bit_idx_d  = 3'd0;
                end
            end
            START_BIT: if (bit_end) state_d = SEND;
            SEND: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) state_d = par_en_q ? PARITY : STOP_BIT1;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            PARITY:    if (bit_end) state_d = STOP_BIT1;
            STOP_BIT1: if (bit_end) state_d = two_stop_q ? STOP_BIT2 : FINISH;
            STOP_BIT2: if (bit_end) state_d = FINISH;
            FINISH: begin
                state_d    = IDLE;
                cnt_baud_d = 32'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is computed from the next state so the pin register lines up with state_q.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START_BIT: tx_d = 1'b0;
            SEND:      tx_d = shift_d[bit_idx_d];
            PARITY:    tx_d = (^shift_d) ^ par_odd_q;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock_125 or negedge rst_n_125) begin
        if (!rst_n_125) begin
            state_q        <= IDLE;
            baud_cnt_max_q <= '0;
            cnt_baud_q     <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            par_en_q       <= 1'b0;
            par_odd_q      <= 1'b0;
            two_stop_q     <= 1'b0;
            tx_q           <= 1'b1;
            ovr_q          <= 1'b0;
        end else if (!rst_done) begin
            state_q        <= IDLE;
            baud_cnt_max_q <= '0;
            cnt_baud_q     <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            par_en_q       <= 1'b0;
            par_odd_q      <= 1'b0;
            two_stop_q     <= 1'b0;
            tx_q           <= 1'b1;
            ovr_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            baud_cnt_max_q <= baud_cnt_max_d;
            cnt_baud_q     <= cnt_baud_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            tx_q           <= tx_d;
            ovr_q          <= pi_flag && !push;
            if (state_q == IDLE) begin
                par_en_q   <= uart_cr[3];
                par_odd_q  <= uart_cr[2];
                two_stop_q <= uart_cr[5];
            end
        end
    end

`ifdef UART_TX_FIFO_EN
    logic [7:0] fifo_mem [16];
    logic [3:0] wr_ptr_q, rd_ptr_q;
    logic [4:0] count_q;

    // Words may queue while TE is low; only a full FIFO drops them.
    assign tx_ready   = (count_q != 5'd16) && uart_cr[1] && (baud_cnt_max_q != 32'd0);
    assign push       = pi_flag && (count_q != 5'd16) && (baud_cnt_max_q != 32'd0);
    assign word_avail = (count_q != 5'd0);
    assign word_data  = fifo_mem[rd_ptr_q];

    always_ff @(posedge clock_125) begin
        if (push) fifo_mem[wr_ptr_q] <= pi_data;
    end

    always_ff @(posedge clock_125 or negedge rst_n_125) begin
        if (!rst_n_125) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (!rst_done) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 4'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 4'd1;
            if (push && !pop)      count_q <= count_q + 5'd1;
            else if (pop && !push) count_q <= count_q - 5'd1;
        end
    end
`else
    logic [7:0] hold_q;
    logic       hold_valid_q;

    assign tx_ready   = (state_q == IDLE) && uart_cr[1] && (baud_cnt_max_q != 32'd0) && !hold_valid_q;
    assign push       = pi_flag && tx_ready;
    assign word_avail = hold_valid_q;
    assign word_data  = hold_q;

    always_ff @(posedge clock_125 or negedge rst_n_125) begin
        if (!rst_n_125) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else if (!rst_done) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else if (push) begin
            hold_q       <= pi_data;
            hold_valid_q <= 1'b1;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end
`endif

    assign tx       = tx_q;
    assign tc_flag  = (state_q == FINISH);
    assign ovr_flag = ovr_q;
endmodule
